// File: rtl/logic_gate_pkg.sv
// Shared definitions for the pipelined logic gate unit: operation select
// width and the eight operation codes.
package logic_gate_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_gate_skid.sv
// Two-entry skid buffer: a primary output register plus one skid register.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid/o_ready   upstream handshake; o_ready depends only on state
//   i_data            payload captured on an accepted beat
//   o_valid/i_ready   downstream handshake
//   o_data            primary register contents
module logic_gate_skid #(
    parameter int unsigned DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_prim_valid;
    logic [DATA_W-1:0] r_prim_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_prim_valid_nxt;
    logic [DATA_W-1:0] w_prim_data_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;

    logic w_push;
    logic w_drain;

    // Upstream may only push while the skid slot is free, so a push can
    // never coincide with an occupied skid.
    assign w_push  = i_valid & ~r_skid_valid;
    assign w_drain = r_prim_valid & i_ready;

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prim_valid <= 1'b0;
            r_prim_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_prim_valid <= w_prim_valid_nxt;
            r_prim_data  <= w_prim_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
        end
    end

    // Next-state: primary refills from skid first (oldest), else from input.
    always_comb begin
        w_prim_valid_nxt = r_prim_valid;
        w_prim_data_nxt  = r_prim_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;

        if (!r_prim_valid || w_drain) begin
            if (r_skid_valid) begin
                w_prim_valid_nxt = 1'b1;
                w_prim_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else if (w_push) begin
                w_prim_valid_nxt = 1'b1;
                w_prim_data_nxt  = i_data;
            end else begin
                w_prim_valid_nxt = 1'b0;
            end
        end else if (w_push) begin
            // Primary is held by backpressure: park the new result.
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = i_data;
        end
    end

    // All outputs come straight from flops; no path from i_ready to o_ready.
    assign o_ready = ~r_skid_valid;
    assign o_valid = r_prim_valid;
    assign o_data  = r_prim_data;

endmodule

// File: rtl/logic_gate_unit.sv
// Pipelined bitwise logic unit: applies one of eight operations to WIDTH-bit
// operands, registers the result with ZERO/PARITY flags, optionally feeds
// the result back through an accumulator, and buffers output in a 2-entry
// skid so in_ready never depends combinationally on out_ready.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake
//   A, B, OP, ACC          operands, operation select, use-accumulator flag
//   CLR_ACC                clears the accumulator on any edge
//   out_valid/out_ready    result handshake
//   Y, ZERO, PARITY        registered result and flags
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  OP,
    input  logic             ACC,
    input  logic             CLR_ACC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO,
    output logic             PARITY
);

    localparam int unsigned DATA_W = WIDTH + 2;

    logic              w_accept;
    logic [WIDTH-1:0]  w_a_eff;
    logic [WIDTH-1:0]  w_result;
    logic              w_zero;
    logic              w_parity;
    logic [DATA_W-1:0] w_skid_in;
    logic [DATA_W-1:0] w_skid_out;

    assign w_accept = in_valid & in_ready;

    // Accumulator: clear has priority over the feedback write.
    if (ACC_EN) begin : g_acc
        logic [WIDTH-1:0] r_acc;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (CLR_ACC) begin
                r_acc <= '0;
            end else if (w_accept) begin
                r_acc <= w_result;
            end
        end

        assign w_a_eff = ACC ? r_acc : A;
    end else begin : g_no_acc
        logic w_unused_acc;
        assign w_unused_acc = ACC ^ CLR_ACC;
        assign w_a_eff      = A;
    end

    // Operation decode.
    always_comb begin
        w_result = '0;
        case (OP)
            OP_AND:  w_result = w_a_eff & B;
            OP_OR:   w_result = w_a_eff | B;
            OP_NOT:  w_result = ~w_a_eff;
            OP_NAND: w_result = ~(w_a_eff & B);
            OP_NOR:  w_result = ~(w_a_eff | B);
            OP_XOR:  w_result = w_a_eff ^ B;
            OP_XNOR: w_result = ~(w_a_eff ^ B);
            OP_PASS: w_result = w_a_eff;
            default: w_result = '0;
        endcase
    end

    // Flags travel with the result so they always match the presented Y.
    assign w_zero    = (w_result == '0);
    assign w_parity  = ^w_result;
    assign w_skid_in = {w_parity, w_zero, w_result};

    logic_gate_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_skid_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_skid_out)
    );

    assign {PARITY, ZERO, Y} = w_skid_out;

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   OP;
    logic         ACC;
    logic         CLR_ACC;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         ZERO;
    logic         PARITY;

    logic [W+1:0] sb[$];
    logic [W-1:0] macc;
    int           total;
    int           bad;
    bit           f;

    logic_gate_unit #(.WIDTH(W), .ACC_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .ACC       (ACC),
        .CLR_ACC   (CLR_ACC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .ZERO      (ZERO),
        .PARITY    (PARITY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] gate(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~a;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // One cycle: check DUT state at negedge against the scoreboard, model the
    // coming edge, then return just after the posedge.
    task automatic tick(output bit fired);
        logic [W-1:0] a_eff;
        logic [W-1:0] r;
        logic         exp_valid;
        logic         exp_ready;
        r = '0;
        @(negedge clk);
        exp_valid = (sb.size() != 0);
        exp_ready = (sb.size() < 2);
        fired = (in_valid === 1'b1) && exp_ready;
        total++;
        assert (out_valid === exp_valid) else begin
            bad++;
            $error("FAIL out_valid got=%b exp=%b", out_valid, exp_valid);
        end
        total++;
        assert (in_ready === exp_ready) else begin
            bad++;
            $error("FAIL in_ready got=%b exp=%b", in_ready, exp_ready);
        end
        if (sb.size() != 0) begin
            total++;
            assert ({PARITY, ZERO, Y} === sb[0]) else begin
                bad++;
                $error("FAIL result {par,zero,y} got=%h exp=%h", {PARITY, ZERO, Y}, sb[0]);
            end
            if (out_ready === 1'b1) void'(sb.pop_front());
        end
        if (fired) begin
            a_eff = ACC ? macc : A;
            r     = gate(OP, a_eff, B);
            sb.push_back({^r, (r == '0), r});
        end
        if (CLR_ACC) macc = '0;
        else if (fired) macc = r;
        @(posedge clk);
        #1;
    endtask

    // Present a beat until accepted (bounded), then drop in_valid.
    task automatic beat(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic acc, input logic clr);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        OP = op; A = a; B = b; ACC = acc; CLR_ACC = clr;
        for (int k = 0; k < 20 && !got; k++) tick(got);
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL beat_accept got=%b exp=%b", got, 1'b1);
        end
        in_valid = 1'b0;
        CLR_ACC  = 1'b0;
    endtask

    task automatic drain();
        bit d;
        in_valid  = 1'b0;
        CLR_ACC   = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) tick(d);
        tick(d);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain_left got=%0d exp=%0d", sb.size(), 0);
        end
    endtask

    initial begin
        total = 0; bad = 0; macc = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; OP = '0; ACC = 1'b0; CLR_ACC = 1'b0;

        // Reset values
        #2;
        total++;
        assert ({out_valid, Y, ZERO, PARITY, in_ready} === {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) else begin
            bad++;
            $error("FAIL reset_state got=%h exp=%h", {out_valid, Y, ZERO, PARITY, in_ready},
                   {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Op sweep on back-to-back beats, out_ready held high
        in_valid = 1'b1; A = 8'hF0; B = 8'hCC; ACC = 1'b0;
        for (int op = 0; op < 8; op++) begin
            OP = 3'(op);
            tick(f);
        end
        drain();

        // Flags
        beat(3'd0, 8'h0F, 8'hF0, 1'b0, 1'b0);
        beat(3'd7, 8'h01, 8'h00, 1'b0, 1'b0);
        drain();

        // Accumulate
        CLR_ACC = 1'b1; tick(f); CLR_ACC = 1'b0;
        beat(3'd1, 8'h00, 8'h01, 1'b1, 1'b0);
        beat(3'd1, 8'h00, 8'h02, 1'b1, 1'b0);
        beat(3'd1, 8'h00, 8'h04, 1'b1, 1'b0);
        beat(3'd5, 8'h00, 8'hFF, 1'b1, 1'b0);
        beat(3'd1, 8'h00, 8'h00, 1'b1, 1'b0);
        beat(3'd5, 8'h00, 8'hFF, 1'b1, 1'b1);
        beat(3'd7, 8'hAA, 8'h00, 1'b1, 1'b0);
        drain();

        // Backpressure: two fill primary and skid, third is held
        out_ready = 1'b0;
        beat(3'd7, 8'h11, 8'h00, 1'b0, 1'b0);
        beat(3'd7, 8'h22, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b1; OP = 3'd7; A = 8'h33; ACC = 1'b0;
        tick(f);
        tick(f);
        out_ready = 1'b1;
        f = 1'b0;
        for (int k = 0; k < 10 && !f; k++) tick(f);
        in_valid = 1'b0;
        drain();

        // Reset with primary and skid full, acc = 5A
        beat(3'd7, 8'h5A, 8'h00, 1'b0, 1'b0);
        drain();
        out_ready = 1'b0;
        beat(3'd7, 8'h00, 8'h00, 1'b1, 1'b0);
        beat(3'd7, 8'h00, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        assert ({out_valid, Y, in_ready} === {1'b0, 8'h00, 1'b1}) else begin
            bad++;
            $error("FAIL mid_reset got=%h exp=%h", {out_valid, Y, in_ready}, {1'b0, 8'h00, 1'b1});
        end
        sb.delete();
        macc = '0;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        beat(3'd7, 8'hC3, 8'h00, 1'b1, 1'b0);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            A         = 8'($urandom);
            B         = 8'($urandom);
            OP        = 3'($urandom_range(0, 7));
            ACC       = ($urandom_range(0, 3) == 0);
            CLR_ACC   = ($urandom_range(0, 7) == 0);
            tick(f);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, pipelined successor to the team's two-input combinational gate block.
- Applies one of eight bitwise operations, selected per transaction, to WIDTH-bit operand vectors.
- Registers the result with ZERO/PARITY flags, supports an optional feedback accumulator, and uses a valid/ready handshake with a 2-entry skid buffer.
- Sits between an operand producer and a result consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- ACC_EN, 1, 1 = accumulator implemented; 0 = ACC/CLR_ACC ignored, no acc register

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- OP  in  3  operation select
- ACC  in  1  use accumulator in place of A for this beat
- CLR_ACC  in  1  clear accumulator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- Y  out  WIDTH  result
- ZERO  out  1  Y == 0
- PARITY  out  1  XOR-reduction of Y

Behaviour:
- OP encoding:
  - 0 AND A&B
  - 1 OR A|B
  - 2 NOT ~A (B ignored)
  - 3 NAND ~(A&B)
  - 4 NOR ~(A|B)
  - 5 XOR A^B
  - 6 XNOR ~(A^B)
  - 7 PASS A
- Accept: a beat transfers on a rising edge when in_valid && in_ready. OP, A, B and ACC are sampled only then.
- Latency: the result of a beat accepted at edge N presents on Y/ZERO/PARITY with out_valid=1 after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- Output handshake: a result transfers when out_valid && out_ready. Y/ZERO/PARITY/out_valid stay stable while out_valid && !out_ready.
- Skid buffer: output register (primary) plus one skid register.
  - in_ready = !skid_valid, registered; no combinational path from out_ready to in_ready.
  - Accept while primary is full and not draining: result goes to skid.
  - Primary drains: skid moves to primary on the same edge.
  - Accept and drain on the same edge with skid empty: new result goes directly to primary.
  - Order is always preserved; no result is lost or duplicated.
- Accumulator (ACC_EN=1):
  - WIDTH-bit register acc.
  - On each accepted beat, operand A_eff = ACC ? acc : A; acc <= result.
  - CLR_ACC is sampled on every edge regardless of in_valid; when high, acc <= 0.
  - CLR_ACC together with an accepted beat: the result uses the pre-clear acc, Y is still produced, and acc ends at 0 (clear wins).
- ACC_EN=0: A_eff = A always; CLR_ACC has no effect.
- Flags are computed from the result and registered with it; they always correspond to the current Y.
- Reset values (asynchronous, while rst_n=0):
  - out_valid=0, Y=0, ZERO=0, PARITY=0
  - skid_valid=0, in_ready=1, acc=0
- Reset mid-operation: pending primary/skid results are discarded and acc is cleared. The first post-reset edge behaves as a clean start.
- WIDTH=1: the same rules apply; PARITY equals Y.

Decomposition:
- Shared package logic_gate_pkg holds:
  - OP code localparams: OP_AND=0 … OP_PASS=7
  - OP_W=3
- Natural sub-module: logic_gate_skid, a parametrised (DATA_W) 2-entry skid buffer.
  - Carries {PARITY, ZERO, Y}, i.e. DATA_W = WIDTH+2.
  - The top module holds the op decode, flag logic and accumulator, then feeds the skid.

Test Plan:
- Op sweep (WIDTH=8, A=8'hF0, B=8'hCC, out_ready=1, ACC=0), OP 0..7 on back-to-back beats -> Y = C0, FC, 0F, 3F, 03, 3C, C3, F0, one per cycle starting one cycle after the first accept. ZERO=0 and PARITY=0 on all beats.
- Flags: OP=0, A=8'h0F, B=8'hF0 -> Y=00, ZERO=1, PARITY=0. OP=7, A=8'h01 -> Y=01, ZERO=0, PARITY=1.
- Accumulate:
  - Pulse CLR_ACC, then ACC=1, OP=1 with B = 01, 02, 04 -> Y = 01, 03, 07.
  - Next beat ACC=1, OP=5, B=8'hFF -> Y=F8.
  - Same beat with CLR_ACC=1 -> Y=F8 and the following ACC beat sees acc=00.
- Backpressure: out_ready=0, offer beats Y=11, 22, 33 (OP=7) -> first two accepted; in_ready=0 after the second; the third is held. Raise out_ready -> outputs 11, 22, 33 in order, no duplicates; in_ready returns to 1 one cycle after the skid drains.
- Simultaneous accept and drain with the skid empty: continuous stream with out_ready=1 -> in_ready stays 1 and no bubble appears.
- Reset mid-stream: assert rst_n=0 with primary and skid full and acc=8'h5A -> immediately out_valid=0, Y=00, in_ready=1. After release, an ACC=1, OP=7 beat gives Y=00.
